// File: rtl/vga_reg_updater.sv
// Mirrors the VGA peripheral register file in a local shadow and pushes the
// dirty entries over Avalon-MM once per frame, starting at the vsync fall.
module vga_reg_updater #(
    parameter int NUM_REGS = 7,
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_write,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    input  logic              force_all,
    input  logic              vga_vs,
    output logic [ADDR_W-1:0] av_address,
    output logic [DATA_W-1:0] av_writedata,
    output logic              av_write,
    output logic              av_chipselect,
    input  logic              av_waitrequest,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);

    localparam int IDX_W = $clog2(NUM_REGS + 1);

    typedef enum logic [2:0] {IDLE, SNAP, SCAN, WRITE, DONE} state_t;

    state_t              state, state_nxt;
    logic                vs_d;
    logic                vs_fall;
    logic [DATA_W-1:0]   shadow  [NUM_REGS];
    logic [DATA_W-1:0]   sendbuf [NUM_REGS];
    logic [NUM_REGS-1:0] dirty;
    logic [NUM_REGS-1:0] pending;
    logic [IDX_W-1:0]    index;
    logic [IDX_W-1:0]    host_idx;
    logic                host_hit;
    logic                at_end;
    logic                cur_pending;
    logic                take_snap;
    logic                load_write;
    logic                advance;
    logic                accept;

    assign vs_fall     = vs_d & ~vga_vs;
    assign host_idx    = host_addr[IDX_W-1:0];
    assign host_hit    = host_write && (host_addr < ADDR_W'(NUM_REGS));
    assign at_end      = (index == IDX_W'(NUM_REGS));
    assign cur_pending = !at_end && pending[index];
    assign av_chipselect = av_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) vs_d <= 1'b1;
        else       vs_d <= vga_vs;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (vs_fall) state_nxt = SNAP;
            SNAP:    state_nxt = SCAN;
            SCAN:    if (at_end) state_nxt = DONE;
                     else if (cur_pending) state_nxt = WRITE;
            WRITE:   if (!av_waitrequest) state_nxt = SCAN;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        take_snap  = 1'b0;
        load_write = 1'b0;
        advance    = 1'b0;
        accept     = 1'b0;
        case (state)
            SNAP:    take_snap = 1'b1;
            SCAN:    begin
                         load_write = cur_pending;
                         advance    = !at_end && !cur_pending;
                     end
            WRITE:   accept = !av_waitrequest;
            default: ;
        endcase
    end

    // Bus outputs, scan position and per-frame pending mask
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            av_address   <= '0;
            av_writedata <= '0;
            av_write     <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            overrun      <= 1'b0;
            index        <= '0;
            pending      <= '0;
        end else begin
            busy       <= (state_nxt != IDLE);
            frame_done <= (state_nxt == DONE);
            if (vs_fall && state != IDLE) overrun <= 1'b1;
            if (take_snap) begin
                pending <= force_all ? '1 : dirty;
                index   <= '0;
            end
            if (load_write) begin
                av_address   <= ADDR_W'(index);
                av_writedata <= sendbuf[index];
                av_write     <= 1'b1;
            end
            if (advance) index <= index + 1'b1;
            if (accept) begin
                av_write       <= 1'b0;
                pending[index] <= 1'b0;
                index          <= index + 1'b1;
            end
        end
    end

    // A host write landing in the SNAP cycle keeps its dirty bit for the next frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
            dirty <= '1;
        end else begin
            if (take_snap) dirty <= '0;
            if (host_hit) begin
                shadow[host_idx] <= host_data;
                dirty[host_idx]  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (take_snap) begin
            for (int i = 0; i < NUM_REGS; i++) sendbuf[i] <= shadow[i];
        end
    end

endmodule
